apb_wait_slave: RTL
===================

APB_WAIT_SLAVE -- requirements
Module: apb_wait_slave

Interface
REQ-001 Parameter WIDTH, default 8: address and data bus width.
REQ-002 Parameter DEPTH, default 16: number of register locations, addresses 0..DEPTH-1.
REQ-003 Parameter WAIT_CYCLES, default 2: number of access-phase cycles with o_PREADY low before completion; legal range 0..7.
REQ-004 Parameter ID_VALUE, default 8'hA5: constant read at address 0.
REQ-005 i_PCLK  in  1  single clock; all state changes on its rising edge.
REQ-006 i_PRESET  in  1  reset, synchronous, active-high.
REQ-007 i_PSEL1  in  1  slave select.
REQ-008 i_PENABLE  in  1  access-phase strobe.
REQ-009 i_PWRITE  in  1  1 = write, 0 = read.
REQ-010 i_paddr  in  WIDTH  transfer address.
REQ-011 i_pwdata  in  WIDTH  write data.
REQ-012 o_prdata  out  WIDTH  read data, valid only while o_PREADY=1 on a read.
REQ-013 o_PREADY  out  1  transfer-complete indication.
REQ-014 o_PSLVERR  out  1  error response, valid only while o_PREADY=1.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT, READY.
REQ-016 A setup phase is i_PSEL1=1, i_PENABLE=0 sampled in IDLE; at that edge i_paddr, i_PWRITE and i_pwdata SHALL be latched and the wait counter cleared.
REQ-017 IDLE -> WAIT on setup when WAIT_CYCLES>0; IDLE -> READY on setup when WAIT_CYCLES=0.
REQ-018 In WAIT, with i_PSEL1=1 and i_PENABLE=1, the counter SHALL increment each cycle; WAIT -> READY at the edge where counter = WAIT_CYCLES-1.
REQ-019 o_PREADY SHALL be 1 only in READY; total access-phase length is exactly WAIT_CYCLES+1 cycles.
REQ-020 READY -> IDLE unconditionally at the next edge; a write SHALL commit to storage at that edge only.
REQ-021 o_PSLVERR SHALL be 1 in READY when latched address >= DEPTH, or when a write targets address 0.
REQ-022 Errored writes SHALL NOT modify storage; errored reads SHALL return o_prdata = 0.
REQ-023 Read of address 0 SHALL return ID_VALUE; read of address 1..DEPTH-1 SHALL return stored value, including a value written in the immediately preceding transfer.
REQ-024 o_prdata SHALL be 0 whenever o_PREADY=0 or the transfer is a write.
REQ-025 i_PSEL1 deasserted in WAIT SHALL abort: return to IDLE, no commit, o_PREADY stays 0.
REQ-026 i_PSEL1=1 and i_PENABLE=1 sampled in IDLE (access without setup) SHALL be ignored: remain IDLE, outputs 0.
REQ-027 Changes on i_paddr, i_PWRITE or i_pwdata after setup SHALL have no effect on the transfer in progress.
REQ-028 Back-to-back: a setup sampled in the cycle after READY SHALL start a new transfer with no extra idle cycle.
REQ-029 The counter width SHALL be 3 bits; no wrap occurs within the legal WAIT_CYCLES range.

Reset
REQ-030 When i_PRESET=1 at an edge: state = IDLE, counter = 0, latched address/data/direction = 0, all storage locations = 0.
REQ-031 During and after reset, o_PREADY=0, o_PSLVERR=0, o_prdata=0.
REQ-032 Reset asserted mid-transfer SHALL discard the transfer with no commit; reset has priority over all other events.

Structure
REQ-033 State encoding constants (IDLE=2'd0, WAIT=2'd1, READY=2'd2) and ID_VALUE default SHALL reside in the shared APB definitions package/header used by the APB blocks.
REQ-034 Storage SHALL be a sub-module apb_wait_slave_regs (DEPTH x WIDTH, one write port, one combinational read port, synchronous reset); FSM, counter and decode stay in apb_wait_slave.

Verification
REQ-035 Write 8'h3C to addr 5, then read addr 5, WAIT_CYCLES=2 -> o_PREADY high on 3rd access cycle each time; read returns 8'h3C, o_PSLVERR=0.
REQ-036 Read addr 0 -> o_prdata=8'hA5; write 8'h11 to addr 0 -> o_PSLVERR=1, subsequent read still 8'hA5.
REQ-037 Write 8'hFF to addr 20 (DEPTH=16) -> o_PSLVERR=1 with o_PREADY; read addr 20 -> o_prdata=0, o_PSLVERR=1.
REQ-038 WAIT_CYCLES=0, back-to-back writes addr 1..3 then reads -> o_PREADY high in first access cycle, data 1..3 returned in order.
REQ-039 Write 8'h77 to addr 4, drop i_PSEL1 during WAIT -> no o_PREADY; read addr 4 returns previous value 8'h00.
REQ-040 Assert i_PRESET in WAIT of a write 8'h55 to addr 6 -> outputs 0 next cycle; read addr 6 returns 8'h00.

Source files
------------

// File: rtl/apb_wait_slave_pkg.sv
// Shared APB definitions: FSM state encoding, counter width and the default ID value.
package apb_wait_slave_pkg;

  // FSM state encoding, kept as plain constants so legacy blocks can share it.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StReady = 2'd2;

  // Wait counter width; covers WAIT_CYCLES up to 7 without wrapping.
  localparam int unsigned CntW = 3;

  // Constant returned by a read of address 0.
  localparam logic [7:0] ApbIdValueDefault = 8'hA5;

  // True on the last wait cycle. For wait_cycles == 0 the target is 7, which the
  // counter never reaches because WAIT is skipped entirely.
  function automatic logic cnt_done(input logic [CntW-1:0] cnt, input int unsigned wait_cycles);
    return cnt == CntW'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/apb_wait_slave_regs.sv
// Register file: DEPTH x WIDTH, one synchronous write port, one combinational read port.
module apb_wait_slave_regs #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Clear every location on reset, otherwise write one location when enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read; the caller masks out-of-range addresses.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/apb_wait_slave.sv
// APB slave with a fixed number of wait states, an ID register at address 0 and a
// small register file behind it. FSM, wait counter and address decode live here.
module apb_wait_slave
  import apb_wait_slave_pkg::*;
#(
  parameter int unsigned       WIDTH       = 8,
  parameter int unsigned       DEPTH       = 16,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [WIDTH-1:0]  ID_VALUE    = WIDTH'(ApbIdValueDefault)
) (
  input  logic             i_PCLK,
  input  logic             i_PRESET,
  input  logic             i_PSEL1,
  input  logic             i_PENABLE,
  input  logic             i_PWRITE,
  input  logic [WIDTH-1:0] i_paddr,
  input  logic [WIDTH-1:0] i_pwdata,
  output logic [WIDTH-1:0] o_prdata,
  output logic             o_PREADY,
  output logic             o_PSLVERR
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             write_q, write_d;

  logic             ready;
  logic             in_range;
  logic             err;
  logic             commit;
  logic [WIDTH-1:0] reg_rdata;

  // Next-state: latch the transfer on setup, count wait cycles, abort on PSEL drop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    case (state_q)
      StIdle: begin
        // PSEL with PENABLE already high is an access without setup and is ignored.
        if (i_PSEL1 && !i_PENABLE) begin
          addr_d  = i_paddr;
          wdata_d = i_pwdata;
          write_d = i_PWRITE;
          cnt_d   = '0;
          state_d = (WAIT_CYCLES == 0) ? StReady : StWait;
        end
      end
      StWait: begin
        if (!i_PSEL1) begin
          state_d = StIdle;
        end else if (i_PENABLE) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_done(cnt_q, WAIT_CYCLES)) begin
            state_d = StReady;
          end
        end
      end
      StReady: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and latched transfer registers; reset wins over everything.
  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  // Decode of the latched transfer: error, commit enable and response outputs.
  always_comb begin
    ready    = (state_q == StReady);
    in_range = (32'(addr_q) < DEPTH);
    err      = ready && (!in_range || (write_q && (addr_q == '0)));
    // Commit happens on the edge that leaves READY.
    commit   = ready && write_q && !err;
    o_PREADY  = ready;
    o_PSLVERR = err;
    o_prdata  = '0;
    if (ready && !write_q && !err) begin
      o_prdata = (addr_q == '0) ? ID_VALUE : reg_rdata;
    end
  end

  apb_wait_slave_regs #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (AddrW)
  ) u_regs (
    .clk_i   (i_PCLK),
    .rst_i   (i_PRESET),
    .we_i    (commit),
    .waddr_i (addr_q[AddrW-1:0]),
    .wdata_i (wdata_q),
    .raddr_i (addr_q[AddrW-1:0]),
    .rdata_o (reg_rdata)
  );

endmodule
